// File: rtl/sr_drive_pkg.sv
// Shared types and defaults for the SR latch drive path.
// Counter width covers both the debounce count and the pulse-length count.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE_SET = 2'd1,
        PULSE_RST = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PULSE_CYCLES    = 4;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Purpose: synchronise, debounce and rising-edge detect one raw push button.
// Latency: req rises SYNC_STAGES+DEBOUNCE_CYCLES edges after the first clean sample.
// Backpressure: none; req is a one-cycle strobe and must be captured by the consumer.
module debounce_channel
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEF_DEBOUNCE_CYCLES, DEF_PULSE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;

    assign sync_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreement restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            req    <= 1'b0;
        end else begin
            req <= 1'b0;
            if (sync_out != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync_out;
                    cnt    <= '0;
                    req    <= sync_out;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sr_drive_debouncer.sv
// Purpose: turn two bouncy buttons into exclusive active-low set/reset pulses for a NAND latch.
// Latency: set_n/reset_n fall SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after a clean press (idle FSM).
// Backpressure: requests arriving while busy wait in a 1-deep pending flag; repeats merge.
module sr_drive_debouncer
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn_raw,
    input  logic reset_btn_raw,
    output logic set_n,
    output logic reset_n,
    output logic busy,
    output logic conflict
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, PULSE_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic             pend_set, pend_rst;
    logic             pend_set_nxt, pend_rst_nxt;
    logic             set_req, rst_req;
    logic             eff_set, eff_rst;

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set_chan (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(set_btn_raw),
        .req    (set_req)
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rst_chan (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(reset_btn_raw),
        .req    (rst_req)
    );

    // A strobe arriving this cycle is treated as already pending so an idle
    // FSM can act on it without a bookkeeping cycle.
    assign eff_set = pend_set | set_req;
    assign eff_rst = pend_rst | rst_req;

    always_comb begin
        state_nxt    = state;
        pcnt_nxt     = pcnt;
        pend_set_nxt = eff_set;
        pend_rst_nxt = eff_rst;
        conflict     = 1'b0;
        case (state)
            IDLE, GAP: begin
                state_nxt = IDLE;
                pcnt_nxt  = '0;
                if (eff_set && eff_rst) begin
                    conflict     = 1'b1;
                    pend_set_nxt = 1'b0;
                    pend_rst_nxt = 1'b0;
                end else if (eff_set) begin
                    state_nxt    = PULSE_SET;
                    pend_set_nxt = 1'b0;
                end else if (eff_rst) begin
                    state_nxt    = PULSE_RST;
                    pend_rst_nxt = 1'b0;
                end
            end
            PULSE_SET, PULSE_RST: begin
                if (pcnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_nxt = GAP;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                pcnt_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
            set_n    <= 1'b1;
            reset_n  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcnt     <= pcnt_nxt;
            pend_set <= pend_set_nxt;
            pend_rst <= pend_rst_nxt;
            set_n    <= (state_nxt != PULSE_SET);
            reset_n  <= (state_nxt != PULSE_RST);
            busy     <= (state_nxt != IDLE);
        end
    end

    a_no_forbidden: assert property (@(posedge clk) disable iff (rst) (set_n || reset_n));

endmodule

// File: tb/tb_sr_drive_debouncer.sv
// Directed bench for sr_drive_debouncer at default parameters, plus a bouncy
// random run that drives a NAND latch model from the DUT outputs.
module tb_sr_drive_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic set_btn_raw;
    logic reset_btn_raw;
    logic set_n;
    logic reset_n;
    logic busy;
    logic conflict;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic latch_q  = 1'b0;

    sr_drive_debouncer dut (
        .clk          (clk),
        .rst          (rst),
        .set_btn_raw  (set_btn_raw),
        .reset_btn_raw(reset_btn_raw),
        .set_n        (set_n),
        .reset_n      (reset_n),
        .busy         (busy),
        .conflict     (conflict)
    );

    always #5 clk = ~clk;

    // Downstream NAND latch, fed from the driver outputs.
    always @(negedge clk) begin
        if (!set_n) latch_q <= 1'b1;
        else if (!reset_n) latch_q <= 1'b0;
    end

    a_tb_forbidden: assert property (@(posedge clk) disable iff (rst) (set_n || reset_n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btn_raw = 1'b0;
        reset_btn_raw = 1'b0;
        idle(3);
        n_checks += 4;
        if (set_n !== 1'b1) begin n_fail++; $display("FAIL reset_set_n: got %b want 1", set_n); end
        if (reset_n !== 1'b1) begin n_fail++; $display("FAIL reset_reset_n: got %b want 1", reset_n); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conflict); end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_clean_press();
        logic exp_set_n, exp_busy;
        set_btn_raw = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_set_n = !(k >= 19 && k <= 22);
            exp_busy  = (k >= 19 && k <= 23);
            n_checks += 3;
            if (set_n !== exp_set_n) begin
                n_fail++; $display("FAIL clean_set_n cycle %0d: got %b want %b", k, set_n, exp_set_n);
            end
            if (reset_n !== 1'b1) begin
                n_fail++; $display("FAIL clean_reset_n cycle %0d: got %b want 1", k, reset_n);
            end
            if (busy !== exp_busy) begin
                n_fail++; $display("FAIL clean_busy cycle %0d: got %b want %b", k, busy, exp_busy);
            end
            if (k == 40) set_btn_raw = 1'b0;
        end
    endtask

    task automatic test_bounce();
        int n_low, first_low;
        n_low = 0;
        first_low = -1;
        for (int t = 0; t < 4; t++) begin
            set_btn_raw = (t % 2 == 0);
            for (int i = 0; i < 5; i++) begin
                tick();
                n_checks++;
                if (set_n !== 1'b1) begin
                    n_fail++; $display("FAIL bounce_early_set_n: got %b want 1", set_n);
                end
            end
        end
        set_btn_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (set_n === 1'b0) begin
                n_low++;
                if (first_low < 0) first_low = k;
            end
        end
        n_checks += 2;
        if (first_low != 19) begin
            n_fail++; $display("FAIL bounce_first_low: got %0d want 19", first_low);
        end
        if (n_low != 4) begin
            n_fail++; $display("FAIL bounce_low_cycles: got %0d want 4", n_low);
        end
        set_btn_raw = 1'b0;
        idle(30);
    endtask

    task automatic test_conflict();
        logic exp_conf;
        set_btn_raw = 1'b1;
        reset_btn_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_conf = (k == 18);
            n_checks += 4;
            if (conflict !== exp_conf) begin
                n_fail++; $display("FAIL conflict_strobe cycle %0d: got %b want %b", k, conflict, exp_conf);
            end
            if (set_n !== 1'b1) begin
                n_fail++; $display("FAIL conflict_set_n cycle %0d: got %b want 1", k, set_n);
            end
            if (reset_n !== 1'b1) begin
                n_fail++; $display("FAIL conflict_reset_n cycle %0d: got %b want 1", k, reset_n);
            end
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL conflict_busy cycle %0d: got %b want 0", k, busy);
            end
        end
        set_btn_raw = 1'b0;
        reset_btn_raw = 1'b0;
        idle(30);
    endtask

    task automatic test_back_to_back();
        logic exp_set_n, exp_reset_n;
        set_btn_raw = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            exp_set_n   = !(k >= 19 && k <= 22);
            exp_reset_n = !(k >= 24 && k <= 27);
            n_checks += 2;
            if (set_n !== exp_set_n) begin
                n_fail++; $display("FAIL b2b_set_n cycle %0d: got %b want %b", k, set_n, exp_set_n);
            end
            if (reset_n !== exp_reset_n) begin
                n_fail++; $display("FAIL b2b_reset_n cycle %0d: got %b want %b", k, reset_n, exp_reset_n);
            end
            if (k == 2) reset_btn_raw = 1'b1;
        end
        set_btn_raw = 1'b0;
        reset_btn_raw = 1'b0;
        idle(30);
    endtask

    task automatic test_reset_mid_pulse();
        set_btn_raw = 1'b1;
        idle(20);
        n_checks++;
        if (set_n !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pre_set_n: got %b want 0", set_n);
        end
        #1;
        rst = 1'b1;
        set_btn_raw = 1'b0;
        #1;
        n_checks += 3;
        if (set_n !== 1'b1) begin n_fail++; $display("FAIL midrst_set_n: got %b want 1", set_n); end
        if (reset_n !== 1'b1) begin n_fail++; $display("FAIL midrst_reset_n: got %b want 1", reset_n); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        idle(3);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++;
            if (set_n !== 1'b1 || reset_n !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after cycle %0d: got set_n=%b reset_n=%b busy=%b want 1 1 0",
                         k, set_n, reset_n, busy);
            end
        end
    endtask

    task automatic drive_btn(input int sel, input logic v);
        if (sel == 0) set_btn_raw = v;
        else reset_btn_raw = v;
    endtask

    task automatic rnd_hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (set_n === 1'b0 && reset_n === 1'b0) begin
                n_fail++; $display("FAIL random_forbidden: got set_n=0 reset_n=0 want not both 0");
            end
        end
    endtask

    task automatic test_random();
        int   sel, nb;
        logic exp_q;
        exp_q = 1'b0;
        for (int seg = 0; seg < 80; seg++) begin
            sel = (seg == 0) ? 0 : int'($urandom_range(0, 2));
            if (sel == 2) begin
                set_btn_raw = 1'b1;
                reset_btn_raw = 1'b1;
                rnd_hold(40);
                set_btn_raw = 1'b0;
                reset_btn_raw = 1'b0;
                rnd_hold(40);
            end else begin
                nb = int'($urandom_range(0, 3));
                for (int b = 0; b < nb; b++) begin
                    drive_btn(sel, 1'b1);
                    rnd_hold(int'($urandom_range(1, 8)));
                    drive_btn(sel, 1'b0);
                    rnd_hold(int'($urandom_range(1, 8)));
                end
                drive_btn(sel, 1'b1);
                rnd_hold(40);
                nb = int'($urandom_range(0, 3));
                for (int b = 0; b < nb; b++) begin
                    drive_btn(sel, 1'b0);
                    rnd_hold(int'($urandom_range(1, 8)));
                    drive_btn(sel, 1'b1);
                    rnd_hold(int'($urandom_range(1, 8)));
                end
                drive_btn(sel, 1'b0);
                rnd_hold(40);
                exp_q = (sel == 0);
            end
            n_checks++;
            if (latch_q !== exp_q) begin
                n_fail++; $display("FAIL random_latch_q seg %0d sel %0d: got %b want %b", seg, sel, latch_q, exp_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_conflict();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
